elbeth_mem_arbiter: RTL and testbench
=====================================

Name: elbeth_mem_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch port (read-only) and the data-access port (load/store).
- Sequences each access with a req/ready handshake and a bounded wait on the memory's ready signal.
- Data accesses use the control unit's 4-bit size/enable code (0000 none, 0001 byte, 0010 halfword, 1000 word) and its sign flag.
- Sits between the IF/MEM pipeline stages and the memory; its ready pulses drive the pipeline stall logic, and its error pulses feed the exception PC select.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles in a BUSY state without mem_ready before abort; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request, level; held until i_ready.
- i_addr  in  ADDR_W  fetch address.
- i_ready  out  1  one-cycle completion pulse.
- i_rdata  out  DATA_W  fetched word; valid while i_ready=1.
- i_err  out  1  one-cycle timeout pulse, coincident with i_ready.
- d_req  in  1  data request, level; held until d_ready.
- d_rw  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_size  in  4  size/enable code.
- d_sign  in  1  sign-extend loaded data.
- d_ready  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  load data, sign/zero-extended per d_size/d_sign; valid while d_ready=1.
- d_err  out  1  one-cycle timeout pulse, coincident with d_ready.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  write strobe; only ever 1 while mem_en=1.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word address to memory.
- mem_wdata  out  DATA_W  lane-aligned store data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion, sampled while mem_en=1.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; last_grant=I; timeout counter=0.
  - All outputs 0.
  - Taking effect mid-transaction aborts the access immediately; mem_en drops asynchronously and no ready or err pulse is produced.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE, requests sampled on the clock edge:
  - Only d_req=1 → BUSY_D.
  - Only i_req=1 → BUSY_I.
  - Both=1 → grant the port not in last_grant. After reset this is D, so D wins the first tie.
  - On entry to a BUSY state: register the address/control/data of the granted port; update last_grant.
- BUSY_x:
  - mem_en=1 and all mem_* outputs are driven from registered copies, so requester inputs may change without effect.
  - mem_ready=1 → capture data, go to DONE_x.
  - Counter increments each BUSY cycle. When it reaches TIMEOUT with mem_ready=0: go to DONE_x with the err flag set.
  - mem_ready takes priority over the timeout in the same cycle.
- DONE_x:
  - x_ready=1 for exactly this cycle; x_err=1 only on timeout; x_rdata valid.
  - mem_en=0. Requests are ignored. Next state is IDLE; the counter clears.
- Requester protocol:
  - Requester drops req in the cycle after ready.
  - Req still high in IDLE is treated as a new request.
- Latency: zero-wait memory gives req sampled at edge N, mem_en in cycle N+1, ready in cycle N+2. Each wait state adds one cycle.
- Byte lanes, with a = addr[1:0]; mem_addr = {addr[ADDR_W-1:2], 2'b00}:
  - Byte: be = 0001<<a; wdata = byte replicated ×4.
  - Halfword: be = 0011<<(a[1]*2); wdata = half replicated ×2.
  - Word: be = 1111.
  - Size 0000, or any other code: be=0000, and no memory access is made. DONE is entered directly from IDLE with d_ready=1 and d_rdata=0.
  - Misaligned offsets are ignored: halfword uses a[1] only; word forces offset 0.
- Load data: select the lane, then sign-extend if d_sign=1, else zero-extend.
- Fetches: be=1111, mem_wr=0 always.

Test Plan:
- Zero-wait fetch, addr=0x104, mem_rdata=0xDEADBEEF → mem_en in cycle 1, i_ready and i_rdata=0xDEADBEEF in cycle 2, i_err=0.
- i_req and d_req both asserted out of reset → D granted first, then I; a second simultaneous pair → D then I again; never two grants in a row while the other port is pending.
- Signed byte load, addr=0x203, mem_rdata=0x80xxxxxx → mem_be=1000, d_rdata=0xFFFFFF80; same load with d_sign=0 → 0x00000080.
- Halfword store, addr=0x0A2, d_wdata=0x1234ABCD → mem_wr=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x0A0.
- mem_ready held 0 with TIMEOUT=4 → mem_en high for 4 cycles, then d_ready=d_err=1 for one cycle, then IDLE.
- rst_n pulled low during BUSY_D with 3 wait states elapsed → mem_en=0 immediately, no d_ready; after release, a pending i_req is served normally.

Source files
------------

// File: rtl/elbeth_mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data load/store.
// Round-robin tie-break, registered request, bounded wait on mem_ready.

module elbeth_mem_lane #(
  parameter int LANE = 0
) (
  input  logic [3:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  always_comb begin
    be    = 1'b0;
    wbyte = 8'h00;
    case (size)
      4'b0001: begin
        be    = (off == 2'(LANE));
        wbyte = wdata[7:0];
      end
      4'b0010: begin
        be    = (off[1] == 1'(LANE / 2));
        wbyte = wdata[8*(LANE%2) +: 8];
      end
      4'b1000: begin
        be    = 1'b1;
        wbyte = wdata[8*LANE +: 8];
      end
      default: ;
    endcase
  end
endmodule

module elbeth_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_size,
  input  logic              d_sign,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int          NUM_LANES = 4;
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        size;
    logic [1:0]        off;
    logic              sign;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic   last_d_q;
  logic   err_q;
  logic [15:0]       cnt_q;
  logic [DATA_W-1:0] rdata_q;

  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wb;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    elbeth_mem_lane #(.LANE(g)) u_lane (
      .size (d_size),
      .off  (d_addr[1:0]),
      .wdata(d_wdata),
      .be   (lane_be[g]),
      .wbyte(lane_wb[g])
    );
  end

  // D wins a tie unless it was the last port granted
  logic gnt_d, gnt_i, size_ok, timeout_hit;
  assign gnt_d       = d_req & (~i_req | ~last_d_q);
  assign gnt_i       = i_req & ~gnt_d;
  assign size_ok     = (d_size == 4'b0001) || (d_size == 4'b0010) || (d_size == 4'b1000);
  assign timeout_hit = (cnt_q == TO_LAST);

  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [DATA_W-1:0] load_ext;

  always_comb begin
    ld_b     = mem_rdata[{req_q.off, 3'b000} +: 8];
    ld_h     = mem_rdata[{req_q.off[1], 4'b0000} +: 16];
    load_ext = mem_rdata;
    case (req_q.size)
      4'b0001: load_ext = req_q.sign ? {{(DATA_W-8){ld_b[7]}}, ld_b}
                                     : {{(DATA_W-8){1'b0}}, ld_b};
      4'b0010: load_ext = req_q.sign ? {{(DATA_W-16){ld_h[15]}}, ld_h}
                                     : {{(DATA_W-16){1'b0}}, ld_h};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_d)      state_d = size_ok ? BUSY_D : DONE_D;
        else if (gnt_i) state_d = BUSY_I;
      end
      BUSY_I:  if (mem_ready || timeout_hit) state_d = DONE_I;
      BUSY_D:  if (mem_ready || timeout_hit) state_d = DONE_D;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      req_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          if (gnt_d) begin
            last_d_q <= 1'b1;
            req_q    <= '{wr: d_rw, addr: {d_addr[ADDR_W-1:2], 2'b00}, be: lane_be,
                          wdata: lane_wb, size: d_size, off: d_addr[1:0], sign: d_sign};
          end else if (gnt_i) begin
            last_d_q <= 1'b0;
            req_q    <= '{wr: 1'b0, addr: {i_addr[ADDR_W-1:2], 2'b00}, be: 4'hF,
                          wdata: '0, size: 4'b1000, off: i_addr[1:0], sign: 1'b0};
          end
        end
        BUSY_I, BUSY_D: begin
          cnt_q <= cnt_q + 16'd1;
          if (mem_ready)        rdata_q <= req_q.wr ? '0 : load_ext;
          else if (timeout_hit) err_q   <= 1'b1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // mem_* are driven only while busy so the bus is quiet otherwise
  assign mem_en    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mem_wr    = (state_q == BUSY_D) && req_q.wr;
  assign mem_be    = mem_en ? req_q.be   : 4'h0;
  assign mem_addr  = mem_en ? req_q.addr : '0;
  assign mem_wdata = mem_wr ? req_q.wdata : '0;

  assign i_ready = (state_q == DONE_I);
  assign i_err   = i_ready & err_q;
  assign i_rdata = i_ready ? rdata_q : '0;
  assign d_ready = (state_q == DONE_D);
  assign d_err   = d_ready & err_q;
  assign d_rdata = d_ready ? rdata_q : '0;
endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Directed bench for elbeth_mem_arbiter; completions checked against a scoreboard queue.
module tb_elbeth_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_req, i_ready, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_rw, d_sign, d_ready, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_size, mem_be;
  logic        mem_en, mem_wr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int          busy_cnt = 0;
  int          ws = 0;
  logic        no_ready = 1'b0;
  logic [31:0] mem_data = 32'h0;

  int tests = 0, fails = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  elbeth_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_sign(d_sign), .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // memory model: ready after ws wait states unless stalled
  assign mem_ready = mem_en && !no_ready && (busy_cnt >= ws);
  assign mem_rdata = mem_data;
  always @(posedge clk) busy_cnt <= mem_en ? busy_cnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic [31:0] rd, input logic err, input logic cd);
    sb_t e;
    e.is_d = is_d; e.rdata = rd; e.err = err; e.chk_data = cd;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (i_ready || d_ready)) begin
      if (sb_q.size() == 0) chk("sb_unexpected", 32'({d_ready, i_ready}), 32'h0);
      else begin
        mon_e = sb_q.pop_front();
        chk("sb_port", 32'(d_ready), 32'(mon_e.is_d));
        chk("sb_both", 32'(i_ready & d_ready), 32'h0);
        chk("sb_err", 32'(d_ready ? d_err : i_err), 32'(mon_e.err));
        if (mon_e.chk_data) chk("sb_data", d_ready ? d_rdata : i_rdata, mon_e.rdata);
      end
    end
  end

  // requester side: drop each req in the cycle after its ready pulse
  task automatic run_until_idle(input int max_cyc);
    logic ir, dr;
    int n = 0;
    while (i_req || d_req) begin
      @(negedge clk);
      ir = i_ready; dr = d_ready;
      @(posedge clk); #1;
      if (ir) i_req = 1'b0;
      if (dr) d_req = 1'b0;
      n++;
      if (n > max_cyc) begin
        chk("run_bound", 32'(n), 32'(max_cyc));
        i_req = 1'b0; d_req = 1'b0;
      end
    end
  endtask

  task automatic d_txn(input string tag, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] size, input logic sign,
                       input logic acc, input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] erd);
    @(posedge clk); #1;
    d_req = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wdata; d_size = size; d_sign = sign;
    push(1'b1, erd, 1'b0, !rw);
    @(negedge clk);
    @(negedge clk);
    if (acc) begin
      chk({tag, "_en"},   32'(mem_en), 32'd1);
      chk({tag, "_wr"},   32'(mem_wr), 32'(rw));
      chk({tag, "_be"},   32'(mem_be), 32'(ebe));
      chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
      if (rw) chk({tag, "_wdata"}, mem_wdata, ewd);
      run_until_idle(20);
    end else begin
      chk({tag, "_noacc"}, 32'(mem_en), 32'd0);
      chk({tag, "_rdy"},   32'(d_ready), 32'd1);
      @(posedge clk); #1;
      d_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_req = 0; i_addr = 0; d_req = 0; d_rw = 0; d_addr = 0; d_wdata = 0; d_size = 0; d_sign = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_flags", 32'({i_ready, i_err, d_ready, d_err, mem_wr, mem_be}), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata | mem_wdata, 32'd0);
    rst_n = 1'b1;

    // zero-wait fetch latency
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h104; mem_data = 32'hDEADBEEF;
    push(1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
    @(negedge clk); chk("f_idle_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("f_en", 32'(mem_en), 32'd1);
    chk("f_addr", mem_addr, 32'h104);
    chk("f_be", 32'(mem_be), 32'hF);
    chk("f_wr", 32'(mem_wr), 32'd0);
    chk("f_early_rdy", 32'(i_ready), 32'd0);
    @(negedge clk);
    chk("f_rdy", 32'(i_ready), 32'd1);
    chk("f_en_off", 32'(mem_en), 32'd0);
    @(posedge clk); #1; i_req = 1'b0;

    // simultaneous requests straight out of reset, then again
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      mem_data = (k == 0) ? 32'h11223344 : 32'h55667788;
      i_req = 1'b1; i_addr = 32'h80;
      d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h40; d_size = 4'b1000; d_sign = 1'b0;
      push(1'b1, mem_data, 1'b0, 1'b1);
      push(1'b0, mem_data, 1'b0, 1'b1);
      run_until_idle(30);
      chk("tie_sb_empty", 32'(sb_q.size()), 32'd0);
    end

    // lane handling
    mem_data = 32'h80123456;
    d_txn("lb_s", 0, 32'h203, 32'h0, 4'b0001, 1, 1, 4'b1000, 32'h0, 32'hFFFFFF80);
    d_txn("lb_u", 0, 32'h203, 32'h0, 4'b0001, 0, 1, 4'b1000, 32'h0, 32'h00000080);
    d_txn("sh",   1, 32'h0A2, 32'h1234ABCD, 4'b0010, 0, 1, 4'b1100, 32'hABCDABCD, 32'h0);
    d_txn("sb",   1, 32'h001, 32'h0000005A, 4'b0001, 0, 1, 4'b0010, 32'h5A5A5A5A, 32'h0);
    d_txn("sw",   1, 32'h003, 32'hCAFEF00D, 4'b1000, 0, 1, 4'b1111, 32'hCAFEF00D, 32'h0);
    mem_data = 32'h80017FFF;
    d_txn("lh_s", 0, 32'h002, 32'h0, 4'b0010, 1, 1, 4'b1100, 32'h0, 32'hFFFF8001);
    d_txn("lh_m", 0, 32'h001, 32'h0, 4'b0010, 1, 1, 4'b0011, 32'h0, 32'h00007FFF);
    d_txn("lw_m", 0, 32'h307, 32'h0, 4'b1000, 1, 1, 4'b1111, 32'h0, 32'h80017FFF);
    d_txn("sz0",  0, 32'h010, 32'h0, 4'b0000, 0, 0, 4'b0000, 32'h0, 32'h0);
    d_txn("sz4",  0, 32'h010, 32'h0, 4'b0100, 0, 0, 4'b0000, 32'h0, 32'h0);

    // timeout with mem_ready never asserted
    no_ready = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h50; d_size = 4'b1000; d_sign = 1'b0;
    push(1'b1, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("to_en", 32'(mem_en), 32'd1);
      chk("to_rdy_early", 32'(d_ready), 32'd0);
    end
    @(negedge clk);
    chk("to_rdy", 32'(d_ready), 32'd1);
    chk("to_err", 32'(d_err), 32'd1);
    chk("to_en_off", 32'(mem_en), 32'd0);
    @(posedge clk); #1; d_req = 1'b0;
    @(negedge clk);
    chk("to_after", 32'({d_ready, d_err, mem_en}), 32'd0);
    no_ready = 1'b0;

    // mem_ready in the last allowed cycle beats the timeout
    ws = 3;
    @(posedge clk); #1;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h54; d_size = 4'b1000;
    push(1'b1, mem_data, 1'b0, 1'b1);
    run_until_idle(20);
    ws = 0;

    // reset in the middle of a stalled data access
    no_ready = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h60; d_size = 4'b1000;
    @(negedge clk);
    @(negedge clk); i_req = 1'b1; i_addr = 32'h70;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rb_en_before", 32'(mem_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rb_en_async", 32'(mem_en), 32'd0);
    chk("rb_no_rdy", 32'({d_ready, d_err}), 32'd0);
    d_req = 1'b0; no_ready = 1'b0;
    @(negedge clk);
    chk("rb_hold", 32'({d_ready, i_ready, mem_en}), 32'd0);
    mem_data = 32'h0BADF00D;
    push(1'b0, 32'h0BADF00D, 1'b0, 1'b1);
    rst_n = 1'b1;
    run_until_idle(20);
    repeat (3) @(negedge clk);
    chk("end_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
